// File: rtl/lsu_ctrl_if.sv
// ---------------------------------------------------------------------------
// lsu_ctrl_if
// Bundles every bus-side signal of the load/store unit:
//   in_*   : op from execute (valid/ready handshake)
//   mem_*  : request/data lines to the pmem-backed data memory
//   out_*  : result to writeback (valid/ready handshake)
// Modports:
//   slave  : the load/store unit itself
//   master : the environment (execute, memory and writeback side)
// ---------------------------------------------------------------------------
interface lsu_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_store;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    logic [4:0]  in_rd;

    logic        mem_ena;
    logic        mem_wen;
    logic [3:0]  mem_mask;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_rdata;
    logic [4:0]  out_rd;
    logic        out_wb;
    logic        out_misalign;

    modport slave (
        input  in_valid, in_store, in_size, in_unsigned, in_addr, in_wdata, in_rd,
        output in_ready,
        output mem_ena, mem_wen, mem_mask, mem_addr, mem_wdata,
        input  mem_rdata,
        output out_valid, out_rdata, out_rd, out_wb, out_misalign,
        input  out_ready
    );

    modport master (
        output in_valid, in_store, in_size, in_unsigned, in_addr, in_wdata, in_rd,
        input  in_ready,
        input  mem_ena, mem_wen, mem_mask, mem_addr, mem_wdata,
        output mem_rdata,
        input  out_valid, out_rdata, out_rd, out_wb, out_misalign,
        output out_ready
    );
endinterface

// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl
// Load/store unit between execute and the data memory. Holds one op at a
// time: IDLE accepts, REQ issues the (single) memory cycle, WAIT covers the
// remaining memory latency, RESP presents the result to writeback.
// Ports:
//   clk    : clock, all state on posedge
//   rst_n  : synchronous active-low reset
//   bus    : lsu_ctrl_if.slave (execute, memory and writeback signals)
// Parameter:
//   MEM_LAT: cycles from issue (REQ = cycle 1) to mem_rdata sample, 1..15
// ---------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_e;

    // Alignment requirement grows with access size; bytes are never misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lo);
        logic mis;
        case (size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = lo[0];
            2'd2:    mis = (lo[1:0] != 2'b00);
            2'd3:    mis = (lo != 3'b000);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    // Memory mask is one-hot with dword at bit 0 and byte at bit 3.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            2'd0:    m = 4'b1000;
            2'd1:    m = 4'b0100;
            2'd2:    m = 4'b0010;
            2'd3:    m = 4'b0001;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Memory returns data right-aligned; widen to 64 bits by size/signedness.
    function automatic logic [63:0] load_extend(input logic [63:0] d, input logic [1:0] size,
                                                input logic uns);
        logic        s;
        logic [63:0] r;
        s = ~uns;
        case (size)
            2'd0:    r = {{56{s & d[7]}},  d[7:0]};
            2'd1:    r = {{48{s & d[15]}}, d[15:0]};
            2'd2:    r = {{32{s & d[31]}}, d[31:0]};
            2'd3:    r = d;
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    state_e      state_q, state_d;
    logic        store_q, store_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_mask_q, mem_mask_d;
    logic [63:0] out_rdata_q, out_rdata_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic        out_wb_q, out_wb_d;
    logic        out_misalign_q, out_misalign_d;

    logic        in_ready_s;
    logic        accept_s;
    logic        misalign_s;
    logic        last_cycle_s;
    logic        sample_s;

    assign accept_s     = bus.in_valid && in_ready_s;
    assign misalign_s   = is_misaligned(bus.in_size, bus.in_addr[2:0]);
    // Final memory cycle: REQ itself when latency is 1, otherwise WAIT at count 1.
    assign last_cycle_s = ((state_q == S_REQ) && (MEM_LAT == 1)) ||
                          ((state_q == S_WAIT) && (cnt_q == 4'd1));
    assign sample_s     = last_cycle_s && !store_q;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            store_q        <= 1'b0;
            size_q         <= 2'd0;
            unsigned_q     <= 1'b0;
            cnt_q          <= 4'd0;
            mem_addr_q     <= 64'd0;
            mem_wdata_q    <= 64'd0;
            mem_mask_q     <= 4'd0;
            out_rdata_q    <= 64'd0;
            out_rd_q       <= 5'd0;
            out_wb_q       <= 1'b0;
            out_misalign_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            store_q        <= store_d;
            size_q         <= size_d;
            unsigned_q     <= unsigned_d;
            cnt_q          <= cnt_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_mask_q     <= mem_mask_d;
            out_rdata_q    <= out_rdata_d;
            out_rd_q       <= out_rd_d;
            out_wb_q       <= out_wb_d;
            out_misalign_q <= out_misalign_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = misalign_s ? S_RESP : S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (last_cycle_s) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (last_cycle_s) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Op capture, latency counter and load-data sampling.
    always_comb begin
        store_d        = store_q;
        size_d         = size_q;
        unsigned_d     = unsigned_q;
        cnt_d          = cnt_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_mask_d     = mem_mask_q;
        out_rdata_d    = out_rdata_q;
        out_rd_d       = out_rd_q;
        out_wb_d       = out_wb_q;
        out_misalign_d = out_misalign_q;

        if (accept_s) begin
            store_d        = bus.in_store;
            size_d         = bus.in_size;
            unsigned_d     = bus.in_unsigned;
            out_rd_d       = bus.in_rd;
            out_wb_d       = ~bus.in_store & ~misalign_s;
            out_misalign_d = misalign_s;
            out_rdata_d    = 64'd0;
            // A misaligned op never reaches memory, so the memory lines keep
            // presenting the previous access.
            if (!misalign_s) begin
                mem_addr_d  = bus.in_addr;
                mem_mask_d  = size_mask(bus.in_size);
                mem_wdata_d = bus.in_wdata << {bus.in_addr[2:0], 3'b000};
            end else begin
                mem_addr_d  = mem_addr_q;
            end
        end else begin
            store_d = store_q;
        end

        if (state_q == S_REQ) begin
            cnt_d = 4'(MEM_LAT - 1);
        end else if (state_q == S_WAIT) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            cnt_d = cnt_q;
        end

        if (sample_s) begin
            out_rdata_d = load_extend(bus.mem_rdata, size_q, unsigned_q);
        end else begin
            out_rdata_d = out_rdata_d;
        end
    end

    // Output decode from the registered state; write enable only in REQ so
    // each store produces exactly one write cycle.
    always_comb begin
        in_ready_s       = (state_q == S_IDLE) && rst_n;
        bus.in_ready     = in_ready_s;
        bus.mem_ena      = (state_q == S_REQ) || (state_q == S_WAIT);
        bus.mem_wen      = (state_q == S_REQ) && store_q;
        bus.mem_mask     = mem_mask_q;
        bus.mem_addr     = mem_addr_q;
        bus.mem_wdata    = mem_wdata_q;
        bus.out_valid    = (state_q == S_RESP);
        bus.out_rdata    = out_rdata_q;
        bus.out_rd       = out_rd_q;
        bus.out_wb       = out_wb_q;
        bus.out_misalign = out_misalign_q;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl
// Directed bench for lsu_ctrl: one instance with MEM_LAT=1 (if1) and one with
// MEM_LAT=3 (if3). Inputs change and outputs are checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    lsu_ctrl_if if1 ();
    lsu_ctrl_if if3 ();

    lsu_ctrl #(.MEM_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    lsu_ctrl #(.MEM_LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present an op on if1 and let it be accepted; returns in the next state.
    task automatic issue1(input logic st, input logic [1:0] sz, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rd);
        if1.in_valid = 1'b1; if1.in_store = st; if1.in_size = sz; if1.in_unsigned = uns;
        if1.in_addr = addr; if1.in_wdata = wd; if1.in_rd = rd;
        step();
        if1.in_valid = 1'b0;
    endtask

    task automatic issue3(input logic st, input logic [1:0] sz, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rd);
        if3.in_valid = 1'b1; if3.in_store = st; if3.in_size = sz; if3.in_unsigned = uns;
        if3.in_addr = addr; if3.in_wdata = wd; if3.in_rd = rd;
        step();
        if3.in_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        if1.in_valid = 1'b0; if1.in_store = 1'b0; if1.in_size = 2'd0; if1.in_unsigned = 1'b0;
        if1.in_addr = 64'd0; if1.in_wdata = 64'd0; if1.in_rd = 5'd0;
        if1.mem_rdata = 64'd0; if1.out_ready = 1'b1;
        if3.in_valid = 1'b0; if3.in_store = 1'b0; if3.in_size = 2'd0; if3.in_unsigned = 1'b0;
        if3.in_addr = 64'd0; if3.in_wdata = 64'd0; if3.in_rd = 5'd0;
        if3.mem_rdata = 64'd0; if3.out_ready = 1'b1;

        // Reset
        @(negedge clk);
        step();
        chk("rst_low_in_ready", if1.in_ready, 1'b0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", if1.in_ready, 1'b1);
        chk("rst_mem_ena", if1.mem_ena, 1'b0);
        chk("rst_mem_wen", if1.mem_wen, 1'b0);
        chk("rst_mem_mask", if1.mem_mask, 4'd0);
        chk("rst_mem_addr", if1.mem_addr, 64'd0);
        chk("rst_mem_wdata", if1.mem_wdata, 64'd0);
        chk("rst_out_valid", if1.out_valid, 1'b0);
        chk("rst_out_rdata", if1.out_rdata, 64'd0);
        chk("rst_out_rd", if1.out_rd, 5'd0);
        chk("rst_out_wb", if1.out_wb, 1'b0);
        chk("rst_out_misalign", if1.out_misalign, 1'b0);
        chk("rst3_in_ready", if3.in_ready, 1'b1);

        // lb 0x80000003, MEM_LAT=1
        issue1(1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'd0, 5'd5);
        chk("lb_req_ena", if1.mem_ena, 1'b1);
        chk("lb_req_wen", if1.mem_wen, 1'b0);
        chk("lb_req_mask", if1.mem_mask, 4'b1000);
        chk("lb_req_addr", if1.mem_addr, 64'h8000_0003);
        chk("lb_req_in_ready", if1.in_ready, 1'b0);
        if1.mem_rdata = 64'h80;
        step();
        chk("lb_resp_valid", if1.out_valid, 1'b1);
        chk("lb_resp_rdata", if1.out_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_resp_wb", if1.out_wb, 1'b1);
        chk("lb_resp_rd", if1.out_rd, 5'd5);
        chk("lb_resp_ena", if1.mem_ena, 1'b0);
        step();
        chk("lb_idle_valid", if1.out_valid, 1'b0);
        chk("lb_idle_ready", if1.in_ready, 1'b1);

        // lhu / lh 0x80000006
        issue1(1'b0, 2'd1, 1'b1, 64'h8000_0006, 64'd0, 5'd6);
        chk("lhu_req_mask", if1.mem_mask, 4'b0100);
        if1.mem_rdata = 64'hBEEF;
        step();
        chk("lhu_rdata", if1.out_rdata, 64'h0000_0000_0000_BEEF);
        step();
        issue1(1'b0, 2'd1, 1'b0, 64'h8000_0006, 64'd0, 5'd6);
        step();
        chk("lh_rdata", if1.out_rdata, 64'hFFFF_FFFF_FFFF_BEEF);
        chk("lh_wb", if1.out_wb, 1'b1);
        step();

        // sw 0x80000004, MEM_LAT=3
        issue3(1'b1, 2'd2, 1'b0, 64'h8000_0004, 64'h1234_5678, 5'd1);
        chk("sw_req_ena", if3.mem_ena, 1'b1);
        chk("sw_req_wen", if3.mem_wen, 1'b1);
        chk("sw_req_mask", if3.mem_mask, 4'b0010);
        chk("sw_req_wdata", if3.mem_wdata, 64'h1234_5678_0000_0000);
        chk("sw_req_addr", if3.mem_addr, 64'h8000_0004);
        step();
        chk("sw_wait1_ena", if3.mem_ena, 1'b1);
        chk("sw_wait1_wen", if3.mem_wen, 1'b0);
        chk("sw_wait1_addr", if3.mem_addr, 64'h8000_0004);
        step();
        chk("sw_wait2_ena", if3.mem_ena, 1'b1);
        chk("sw_wait2_wen", if3.mem_wen, 1'b0);
        chk("sw_wait2_valid", if3.out_valid, 1'b0);
        step();
        chk("sw_resp_ena", if3.mem_ena, 1'b0);
        chk("sw_resp_valid", if3.out_valid, 1'b1);
        chk("sw_resp_wb", if3.out_wb, 1'b0);
        chk("sw_resp_rdata", if3.out_rdata, 64'd0);
        step();

        // ld 0x80000010, MEM_LAT=3: only the third memory cycle is sampled
        issue3(1'b0, 2'd3, 1'b0, 64'h8000_0010, 64'd0, 5'd2);
        if3.mem_rdata = 64'hDEAD;
        step();
        step();
        if3.mem_rdata = 64'h1122_3344_5566_7788;
        step();
        if3.mem_rdata = 64'h0;
        chk("ld3_resp_valid", if3.out_valid, 1'b1);
        chk("ld3_resp_rdata", if3.out_rdata, 64'h1122_3344_5566_7788);
        step();

        // ld misaligned 0x80000004 on MEM_LAT=1
        if1.in_valid = 1'b1; if1.in_store = 1'b0; if1.in_size = 2'd3; if1.in_unsigned = 1'b0;
        if1.in_addr = 64'h8000_0004; if1.in_rd = 5'd8;
        step();
        if1.in_valid = 1'b0;
        chk("mis_ena", if1.mem_ena, 1'b0);
        chk("mis_valid", if1.out_valid, 1'b1);
        chk("mis_flag", if1.out_misalign, 1'b1);
        chk("mis_rdata", if1.out_rdata, 64'd0);
        chk("mis_wb", if1.out_wb, 1'b0);
        chk("mis_addr_held", if1.mem_addr, 64'h8000_0006);
        step();

        // lw 0x80000008 with writeback stalled for 5 cycles
        if1.out_ready = 1'b0;
        issue1(1'b0, 2'd2, 1'b0, 64'h8000_0008, 64'd0, 5'd7);
        if1.mem_rdata = 64'h0000_0000_8000_0001;
        step();
        if1.mem_rdata = 64'h0;
        if1.in_valid = 1'b1; if1.in_store = 1'b0; if1.in_size = 2'd3; if1.in_unsigned = 1'b0;
        if1.in_addr = 64'h8000_0020; if1.in_rd = 5'd9;
        chk("bp_valid", if1.out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", if1.out_valid, 1'b1);
            chk("bp_hold_rdata", if1.out_rdata, 64'hFFFF_FFFF_8000_0001);
            chk("bp_hold_rd", if1.out_rd, 5'd7);
            chk("bp_hold_in_ready", if1.in_ready, 1'b0);
            chk("bp_hold_ena", if1.mem_ena, 1'b0);
        end
        if1.out_ready = 1'b1;
        step();
        chk("bp_rel_valid", if1.out_valid, 1'b0);
        chk("bp_rel_in_ready", if1.in_ready, 1'b1);
        step();
        if1.in_valid = 1'b0;
        chk("bp_next_ena", if1.mem_ena, 1'b1);
        chk("bp_next_addr", if1.mem_addr, 64'h8000_0020);
        chk("bp_next_mask", if1.mem_mask, 4'b0001);
        if1.mem_rdata = 64'hCAFE;
        step();
        chk("bp_next_rdata", if1.out_rdata, 64'hCAFE);
        chk("bp_next_rd", if1.out_rd, 5'd9);
        step();

        // Reset while a load waits on MEM_LAT=3
        issue3(1'b0, 2'd3, 1'b0, 64'h8000_0018, 64'd0, 5'd3);
        step();
        chk("rw_wait_ena", if3.mem_ena, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("rw_in_ready", if3.in_ready, 1'b1);
        chk("rw_mem_ena", if3.mem_ena, 1'b0);
        chk("rw_mem_wen", if3.mem_wen, 1'b0);
        chk("rw_mem_mask", if3.mem_mask, 4'd0);
        chk("rw_mem_addr", if3.mem_addr, 64'd0);
        chk("rw_mem_wdata", if3.mem_wdata, 64'd0);
        chk("rw_out_valid", if3.out_valid, 1'b0);
        chk("rw_out_rdata", if3.out_rdata, 64'd0);
        chk("rw_out_rd", if3.out_rd, 5'd0);
        chk("rw_out_wb", if3.out_wb, 1'b0);
        chk("rw_out_misalign", if3.out_misalign, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rw_no_valid", if3.out_valid, 1'b0);
            chk("rw_no_ena", if3.mem_ena, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
